// File: rtl/mp_seq_core_if.sv
`default_nettype none
// ============================================================================
// Module      : mp_seq_core_if
// Description : Slave bus bundle for mp_seq_core.
//               sel  - slave select
//               wr   - 1 = write, 0 = read (qualified by sel)
//               addr - 16-bit word address
//               din  - 32-bit write data
//               dout - DATA_W-bit registered read data
// Revision    : 1.0 - initial release
// ============================================================================
interface mp_seq_core_if #(
  parameter int DATA_W = 32
) ();

  logic              sel;
  logic              wr;
  logic [15:0]       addr;
  logic [31:0]       din;
  logic [DATA_W-1:0] dout;

  modport master (output sel, output wr, output addr, output din, input dout);
  modport slave  (input sel, input wr, input addr, input din, output dout);

endinterface
`default_nettype wire

// File: rtl/mp_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : mp_seq_core
// Description : Bus-slave mini sequencer. Holds control, instruction and data
//               registers behind one slave port and runs the stored program
//               (ALU ops plus a shift-add multiply). Completion raises a
//               level interrupt.
// Ports       : clk             - clock, rising edge
//               rst             - asynchronous active-high reset
//               bus             - slave bus (sel/wr/addr/din in, dout out)
//               o_interrupt_out - level interrupt = done & int_en
// Map         : 0x000 CTRL (W bit0 start)     0x001 INT_EN (RW bit0)
//               0x002 STATUS {N,Z,err,busy,done} (W bit0 clears done/err)
//               0x003 PC (R)   0x100+i INST[i]   0x200+i DATA[i]
// Revision    : 1.0 - initial release
// ============================================================================
module mp_seq_core #(
  parameter int DATA_W     = 32,
  parameter int DATA_DEPTH = 16,
  parameter int INST_DEPTH = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mp_seq_core_if.slave       bus,
  output logic               o_interrupt_out
);

  localparam int c_da_w  = $clog2(DATA_DEPTH);
  localparam int c_ia_w  = $clog2(INST_DEPTH);
  localparam int c_cnt_w = $clog2(DATA_W);

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_xor  = 4'h5;
  localparam logic [3:0] c_op_mul  = 4'h6;
  localparam logic [3:0] c_op_halt = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MUL_RUN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Architectural registers
  logic [31:0]       r_inst [INST_DEPTH];
  logic [DATA_W-1:0] r_data [DATA_DEPTH];
  logic [c_ia_w-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_int_en;
  logic              r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_n;
  logic              r_z;

  // Multiplier: high half accumulates, low half starts as the multiplier and
  // shifts out one bit per cycle as product bits shift in.
  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mcand;
  logic [c_cnt_w-1:0]  r_mul_cnt;

  // Bus decode
  logic w_bus_wr;
  logic w_bus_rd;
  logic w_inst_hit;
  logic w_data_hit;
  logic w_start;
  logic w_status_clr;
  logic [DATA_W-1:0] w_rd_data;

  // Instruction fields
  logic [3:0]        w_op;
  logic [c_da_w-1:0] w_dst;
  logic [c_da_w-1:0] w_dst_hi;
  logic [DATA_W-1:0] w_s1;
  logic [DATA_W-1:0] w_s2;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_pc_last;

  // Multiplier step
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_prod_nxt;
  logic                w_mul_last;

  // FSM strobes
  logic w_fetch;
  logic w_alu_wr;
  logic w_mul_load;
  logic w_mul_step;
  logic w_mul_wr;
  logic w_pc_inc;
  logic w_err_set;
  logic w_done_set;

  logic w_unused_ok;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_bus_wr   = bus.sel & bus.wr;
  assign w_bus_rd   = bus.sel & ~bus.wr;
  // Offsets beyond the register depth are unmapped rather than aliased.
  assign w_inst_hit = (bus.addr[15:8] == 8'h01) && ((bus.addr[7:0] >> c_ia_w) == 8'd0);
  assign w_data_hit = (bus.addr[15:8] == 8'h02) && ((bus.addr[7:0] >> c_da_w) == 8'd0);

  assign w_start      = w_bus_wr && (bus.addr == 16'h0000) && bus.din[0] && !r_busy
                        && (r_state == S_IDLE);
  assign w_status_clr = w_bus_wr && (bus.addr == 16'h0002) && bus.din[0];

  always_comb begin
    w_rd_data = '0;
    if (bus.addr == 16'h0001) begin
      w_rd_data = DATA_W'(r_int_en);
    end else if (bus.addr == 16'h0002) begin
      w_rd_data = DATA_W'({r_n, r_z, r_err, r_busy, r_done});
    end else if (bus.addr == 16'h0003) begin
      w_rd_data = DATA_W'(r_pc);
    end else if (w_inst_hit) begin
      w_rd_data = r_inst[bus.addr[c_ia_w-1:0]][DATA_W-1:0];
    end else if (w_data_hit) begin
      w_rd_data = r_data[bus.addr[c_da_w-1:0]];
    end
  end

  assign o_interrupt_out = r_done & r_int_en;

  // --------------------------------------------------------------------------
  // Datapath combinational logic
  // --------------------------------------------------------------------------
  assign w_op      = r_ir[31:28];
  assign w_dst     = r_ir[16 +: c_da_w];
  assign w_dst_hi  = w_dst + c_da_w'(1);
  assign w_s1      = r_data[r_ir[8 +: c_da_w]];
  assign w_s2      = r_data[r_ir[0 +: c_da_w]];
  assign w_pc_last = (r_pc == c_ia_w'(INST_DEPTH - 1));

  always_comb begin
    w_alu_res = '0;
    case (w_op)
      c_op_add: w_alu_res = w_s1 + w_s2;
      c_op_sub: w_alu_res = w_s1 - w_s2;
      c_op_and: w_alu_res = w_s1 & w_s2;
      c_op_or:  w_alu_res = w_s1 | w_s2;
      c_op_xor: w_alu_res = w_s1 ^ w_s2;
      default:  w_alu_res = '0;
    endcase
  end

  assign w_mul_sum  = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                    + {1'b0, (r_prod[0] ? r_mcand : {DATA_W{1'b0}})};
  assign w_prod_nxt = {w_mul_sum, r_prod[DATA_W-1:1]};
  assign w_mul_last = (r_mul_cnt == c_cnt_w'(DATA_W - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_alu_wr    = 1'b0;
    w_mul_load  = 1'b0;
    w_mul_step  = 1'b0;
    w_mul_wr    = 1'b0;
    w_pc_inc    = 1'b0;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          c_op_nop, c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: begin
            w_alu_wr    = (w_op != c_op_nop);
            w_pc_inc    = 1'b1;
            w_state_nxt = w_pc_last ? S_DONE : S_FETCH;
          end
          c_op_mul: begin
            w_mul_load  = 1'b1;
            w_state_nxt = S_MUL_RUN;
          end
          c_op_halt: begin
            w_state_nxt = S_DONE;
          end
          default: begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DONE;
          end
        endcase
      end
      S_MUL_RUN: begin
        w_mul_step = 1'b1;
        if (w_mul_last) begin
          w_mul_wr    = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = w_pc_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_done_set  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INST_DEPTH; i++) begin
        r_inst[i] <= '0;
      end
      for (int i = 0; i < DATA_DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_pc      <= '0;
      r_ir      <= '0;
      r_int_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_n       <= 1'b0;
      r_z       <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mul_cnt <= '0;
      bus.dout  <= '0;
    end else begin
      if (w_bus_rd) begin
        bus.dout <= w_rd_data;
      end

      if (w_bus_wr && (bus.addr == 16'h0001)) begin
        r_int_en <= bus.din[0];
      end

      // The core only writes registers while busy and the bus only while
      // idle, so these never target the same cycle.
      if (w_bus_wr && !r_busy && w_inst_hit) begin
        r_inst[bus.addr[c_ia_w-1:0]] <= bus.din;
      end
      if (w_bus_wr && !r_busy && w_data_hit) begin
        r_data[bus.addr[c_da_w-1:0]] <= bus.din[DATA_W-1:0];
      end

      if (w_status_clr) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      // Placed after the clear so a same-cycle set wins.
      if (w_done_set) begin
        r_done <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end

      if (w_start) begin
        r_busy <= 1'b1;
        r_pc   <= '0;
      end else if (w_done_set) begin
        r_busy <= 1'b0;
      end

      if (w_pc_inc) begin
        r_pc <= r_pc + c_ia_w'(1);
      end

      if (w_fetch) begin
        r_ir <= r_inst[r_pc];
      end

      if (w_alu_wr) begin
        r_data[w_dst] <= w_alu_res;
        r_n           <= w_alu_res[DATA_W-1];
        r_z           <= (w_alu_res == '0);
      end

      if (w_mul_load) begin
        r_mcand   <= w_s1;
        r_prod    <= {{DATA_W{1'b0}}, w_s2};
        r_mul_cnt <= '0;
      end else if (w_mul_step) begin
        r_prod    <= w_prod_nxt;
        r_mul_cnt <= r_mul_cnt + c_cnt_w'(1);
      end

      // Flags come from the full double-width product.
      if (w_mul_wr) begin
        r_data[w_dst]    <= w_prod_nxt[DATA_W-1:0];
        r_data[w_dst_hi] <= w_prod_nxt[2*DATA_W-1:DATA_W];
        r_n              <= w_prod_nxt[2*DATA_W-1];
        r_z              <= (w_prod_nxt == '0);
      end
    end
  end

  // Reserved instruction bits and din bits above DATA_W are intentionally ignored.
  assign w_unused_ok = ^{r_ir, bus.din};

endmodule
`default_nettype wire

// File: tb/tb_mp_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_seq_core
// Description : Directed self-checking bench for mp_seq_core
//               (DATA_W=32, depths 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_seq_core;

  logic clk;
  logic rst;
  logic irq;
  int   n_pass;
  int   n_total;

  mp_seq_core_if #(.DATA_W(32)) bus_if ();

  mp_seq_core #(
    .DATA_W     (32),
    .DATA_DEPTH (16),
    .INST_DEPTH (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if.slave),
    .o_interrupt_out (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    bus_if.sel  = 1'b1;
    bus_if.wr   = 1'b1;
    bus_if.addr = a;
    bus_if.din  = d;
    @(posedge clk); #1;
    bus_if.sel  = 1'b0;
    bus_if.wr   = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    bus_if.sel  = 1'b1;
    bus_if.wr   = 1'b0;
    bus_if.addr = a;
    @(posedge clk); #1;
    bus_if.sel  = 1'b0;
    d = bus_if.dout;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Start the program and hold a STATUS read; each sample shows the
  // previous cycle's busy bit, so n equals the number of busy cycles.
  task automatic start_count(output int n);
    bus_wr(16'h0000, 32'h1);
    bus_if.sel  = 1'b1;
    bus_if.wr   = 1'b0;
    bus_if.addr = 16'h0002;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus_if.dout[1]) n++;
      else break;
    end
    bus_if.sel = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 100; i++) begin
      bus_rd(16'h0002, s);
      if (s[0]) break;
    end
    chk(tag, {31'd0, s[0]}, 32'h1);
  endtask

  logic [31:0] v;
  int          n;

  initial begin
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    bus_if.sel  = 1'b0;
    bus_if.wr   = 1'b0;
    bus_if.addr = '0;
    bus_if.din  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- 1: reset mid-run ----
    bus_wr(16'h0200, 32'd5);
    bus_wr(16'h0100, 32'h1002_0001);
    bus_rd(16'h0200, v);
    chk("pre_rst_data0", v, 32'd5);
    bus_wr(16'h0000, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_dout", bus_if.dout, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_rd(16'h0002, v);
    chk("rst_status", v, 32'h0);
    bus_rd(16'h0200, v);
    chk("rst_data0", v, 32'h0);
    bus_rd(16'h0100, v);
    chk("rst_inst0", v, 32'h0);
    bus_rd(16'h0202, v);
    chk("rst_data2", v, 32'h0);

    // ---- 2: ADD + HALT with interrupt ----
    bus_wr(16'h0200, 32'd5);
    bus_wr(16'h0201, 32'd7);
    bus_wr(16'h0100, 32'h1002_0001);
    bus_wr(16'h0101, 32'hF000_0000);
    bus_wr(16'h0001, 32'h1);
    bus_wr(16'h0000, 32'h1);
    n = 0;
    while (!irq && n < 7) begin
      @(posedge clk); #1;
      n++;
    end
    chk("add_irq", {31'd0, irq}, 32'h1);
    chk("add_irq_latency", n, 32'd5);
    bus_rd(16'h0202, v);
    chk("add_data2", v, 32'd12);
    bus_rd(16'h0002, v);
    chk("add_status", v, 32'h01);
    bus_rd(16'h0003, v);
    chk("add_pc", v, 32'd1);
    bus_wr(16'h0002, 32'h1);
    chk("add_irq_clr", {31'd0, irq}, 32'h0);
    bus_wr(16'h0110, 32'hDEAD_BEEF);
    bus_rd(16'h0100, v);
    chk("unmapped_no_alias", v, 32'h1002_0001);
    bus_rd(16'h0110, v);
    chk("unmapped_inst_rd", v, 32'h0);
    bus_rd(16'h0050, v);
    chk("unmapped_rd", v, 32'h0);

    // ---- 3: MUL + HALT ----
    do_reset();
    bus_wr(16'h0200, 32'hFFFF_FFFF);
    bus_wr(16'h0201, 32'd2);
    bus_wr(16'h0100, 32'h6004_0001);
    bus_wr(16'h0101, 32'hF000_0000);
    start_count(n);
    // 2 + 32 for MUL, 2 for HALT, 1 for DONE
    chk("mul_busy_cycles", n, 32'd37);
    bus_rd(16'h0204, v);
    chk("mul_lo", v, 32'hFFFF_FFFE);
    bus_rd(16'h0205, v);
    chk("mul_hi", v, 32'h1);
    bus_rd(16'h0002, v);
    chk("mul_status", v, 32'h01);

    // ---- 4: flags ----
    do_reset();
    bus_wr(16'h0200, 32'd5);
    bus_wr(16'h0201, 32'd5);
    bus_wr(16'h0202, 32'd3);
    bus_wr(16'h0100, 32'h2003_0001);
    bus_wr(16'h0101, 32'hF000_0000);
    bus_wr(16'h0000, 32'h1);
    wait_done("sub_zero_done");
    bus_rd(16'h0203, v);
    chk("sub_zero_res", v, 32'h0);
    bus_rd(16'h0002, v);
    chk("sub_zero_status", v, 32'h09);
    bus_wr(16'h0002, 32'h1);
    bus_wr(16'h0100, 32'h2004_0200);
    bus_wr(16'h0000, 32'h1);
    wait_done("sub_neg_done");
    bus_rd(16'h0204, v);
    chk("sub_neg_res", v, 32'hFFFF_FFFE);
    bus_rd(16'h0002, v);
    chk("sub_neg_status", v, 32'h11);

    // ---- 5: protection while busy, illegal opcode ----
    do_reset();
    bus_wr(16'h0200, 32'd5);
    bus_wr(16'h0201, 32'd7);
    bus_wr(16'h0100, 32'h6004_0001);
    bus_wr(16'h0101, 32'h7000_0000);
    bus_wr(16'h0000, 32'h1);
    bus_wr(16'h0200, 32'd9);
    bus_wr(16'h0000, 32'h1);
    wait_done("ill_done");
    bus_rd(16'h0200, v);
    chk("prot_data0", v, 32'd5);
    bus_rd(16'h0204, v);
    chk("prot_mul_lo", v, 32'd35);
    bus_rd(16'h0205, v);
    chk("prot_mul_hi", v, 32'd0);
    bus_rd(16'h0002, v);
    chk("ill_status", v, 32'h05);
    bus_rd(16'h0003, v);
    chk("ill_pc", v, 32'd1);

    // ---- 6: no HALT (reset leaves 16 NOPs), then reset during MUL_RUN ----
    do_reset();
    start_count(n);
    chk("wrap_busy_cycles", n, 32'd33);
    bus_rd(16'h0003, v);
    chk("wrap_pc", v, 32'd0);
    bus_rd(16'h0002, v);
    chk("wrap_status", v, 32'h01);

    do_reset();
    bus_wr(16'h0200, 32'd3);
    bus_wr(16'h0201, 32'd4);
    bus_wr(16'h0100, 32'h6004_0001);
    bus_wr(16'h0000, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    bus_rd(16'h0204, v);
    chk("mulrst_lo", v, 32'h0);
    bus_rd(16'h0205, v);
    chk("mulrst_hi", v, 32'h0);
    bus_rd(16'h0002, v);
    chk("mulrst_status", v, 32'h0);
    chk("mulrst_irq", {31'd0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
